rr_arbiter_n: RTL and testbench
===============================

# rr_arbiter_n

Parametrised N-way round-robin arbiter with registered one-hot grant, per-channel weighted burst credit, and grant hold until the downstream acknowledges beats. It is the next generation of our 3-way arbiter. It sits between N requesting masters and one shared downstream port, such as a bus or FIFO write side. Each grant is held for up to `weight` accepted beats, and the priority pointer rotates past the last winner.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `CW`, default 4: width of each per-channel weight/credit field.
- `IW`, default `$clog2(N)`: width of grant index (derived, do not override).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  arbitration enable; low blocks new grants only.
- `req`  in  N  per-channel request level; bit i = master i.
- `weight`  in  N*CW  flat per-channel weights; channel i uses bits [i*CW +: CW]. Sampled only at grant start. 0 is treated as 1.
- `ack`  in  1  downstream accepted one beat from the current grantee this cycle.
- `gnt`  out  N  registered one-hot grant, or all zero.
- `gnt_idx`  out  IW  registered index of the grantee; valid when `busy`.
- `busy`  out  1  registered; high while a grant is held (`gnt != 0`).

## Operation
- State: `ptr` (IW bits, highest-priority channel), `cur` (IW), `credit` (CW), FSM {IDLE, GRANT}.
- Winner selection (combinational): first i in the order `ptr`, `ptr+1`, …, `N-1`, `0`, …, `ptr-1` with `req[i]=1`. Implement as a double-width masked priority encode. No loops are unrolled over time.
- IDLE:
  - If `en && |req`, register `gnt=onehot(win)`, `gnt_idx=win`, `cur=win`, `credit=max(weight[win],1)`, and go to GRANT.
  - Otherwise stay in IDLE with all outputs 0.
- GRANT, per cycle:
  - Release condition: `(ack && credit==1) || !req[cur]`.
  - If not releasing and `ack`: `credit` decrements by 1. The grant stays.
  - On release: `ptr <= (cur+1) mod N`, with wrap at N, not 2^IW.
  - On release, if `en` and some requester is high, choose the next winner using the updated pointer. Its grant registers in the same edge, so there is no bubble. This includes the released channel itself if it is the only requester.
  - On release with no requester or `en` low: clear outputs and go to IDLE.
- The next winner excludes nothing explicitly. Rotation alone gives fairness.
- `ack` while in IDLE is ignored. `ack` with `!req[cur]` in the same cycle is counted as the final beat; release happens either way.
- `weight` changes during a grant have no effect until the next grant start.
- `en` deasserted mid-grant does not truncate the current grant. It only suppresses the re-grant at release.
- No wrap or underflow is possible on `credit`: a decrement never occurs at 1.

## Timing
- Reset (`rst` high at an edge): `gnt=0`, `gnt_idx=0`, `busy=0`, `ptr=0`, `credit=0`, FSM=IDLE. Reset wins over every other event, including mid-grant; no release bookkeeping is performed.
- Request-to-grant latency is 1 cycle: `req` high at edge t (IDLE, `en`=1) gives `gnt` valid after edge t.
- Release-to-next-grant latency is 0 bubbles: the new `gnt` appears on the same edge that retires the old one.
- A grant lasts at least 1 cycle and at most `max(weight,1)` acks, plus any stall cycles without ack.
- `gnt`, `gnt_idx` and `busy` are always mutually consistent and change only on clock edges.

## Test plan
1. **Reset:** hold `rst` for 2 cycles with `req=4'b1111` → `gnt=0`, `busy=0`, `gnt_idx=0`. First grant after release of `rst` is to channel 0.
2. **Fair rotation:** N=4, all weights 1, `req=4'b1111`, `ack` held high → `gnt` sequence 0001, 0010, 0100, 1000, 0001, one per cycle, `busy` continuously high.
3. **Weighted burst:**
   - Weights {ch0=3, ch1=0}, `req=4'b0011`, `ack`=1 → ch0 for 3 cycles, ch1 for 1 cycle (0 treated as 1), then ch0 again.
   - Inserting one `ack`=0 cycle extends ch0 to 4 cycles.
4. **Sole requester and early drop:**
   - Only ch2 requests, weight 2, `ack`=1 → ch2 is re-granted back-to-back with no bubble.
   - Drop `req[2]` mid-burst → `gnt` is 0 on the next edge and `ptr` becomes 3.
   - A following `req=4'b1001` grants ch3 first.
5. **Enable gating:** ch1 granted with weight 4; deassert `en` after the 1st ack → ch1 completes all 4 acks, then `gnt=0` with `req` still high. Re-asserting `en` grants ch2 if it requests, else the next requester in order from ch2.
6. **Reset mid-grant:** ch3 granted with credit 2, `rst` pulsed for 1 cycle → outputs 0 on the next edge, `ptr=0`, and the next grant goes to the lowest-index requester.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with weighted burst credit and ack-paced grant hold
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int CW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] weight,
    input  logic            ack,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q, cur_q;
    logic [CW-1:0]   credit_q;
    logic [N-1:0]    gnt_q;
    logic            busy_q;

    logic [IW-1:0]   ptr_d, win_d, cur_inc;
    logic [CW-1:0]   credit_d;
    logic [2*N-1:0]  req2, masked;
    logic            release_d, load_d;
    int              pos;

    always_comb begin
        cur_inc   = (cur_q == IW'(N - 1)) ? '0 : cur_q + 1'b1;
        release_d = (state_q == GRANT) && ((ack && credit_q == CW'(1)) || !req[cur_q]);
        ptr_d     = release_d ? cur_inc : ptr_q;
        load_d    = en && (|req) && (state_q == IDLE || release_d);

        // Upper copy of req guarantees a hit once bits below ptr are masked off.
        req2   = {req, req};
        masked = '0;
        for (int i = 0; i < 2*N; i++) begin
            masked[i] = req2[i] && (i >= int'(ptr_d));
        end
        pos = 0;
        for (int i = 2*N - 1; i >= 0; i--) begin
            if (masked[i]) pos = i;
        end
        win_d = IW'((pos >= N) ? pos - N : pos);

        credit_d = weight[int'(win_d)*CW +: CW];
        if (credit_d == '0) credit_d = CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cur_q    <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (load_d) begin
                state_q  <= GRANT;
                cur_q    <= win_d;
                credit_q <= credit_d;
                gnt_q    <= N'(1) << win_d;
                busy_q   <= 1'b1;
            end else if (release_d) begin
                state_q  <= IDLE;
                cur_q    <= '0;
                credit_q <= '0;
                gnt_q    <= '0;
                busy_q   <= 1'b0;
            end else if (state_q == GRANT && ack) begin
                credit_q <= credit_q - 1'b1;
            end
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = cur_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - self-checking bench for rr_arbiter_n (directed scenarios plus random vs. model)
module tb_rr_arbiter_n;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst, en, ack;
    logic [N-1:0]    req;
    logic [N*CW-1:0] weight;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_idx;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: who holds the grant, how many beats remain, where priority starts.
    bit m_on;
    int m_ptr, m_cur, m_credit;

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(N), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .weight  (weight),
        .ack     (ack),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    function automatic void m_pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i]) begin
                int w;
                w        = int'(weight[i*CW +: CW]);
                m_on     = 1'b1;
                m_cur    = i;
                m_credit = (w == 0) ? 1 : w;
                return;
            end
        end
    endfunction

    function automatic void m_step();
        if (rst) begin
            m_on = 1'b0; m_ptr = 0; m_cur = 0; m_credit = 0;
        end else if (!m_on) begin
            if (en && req != '0) m_pick();
        end else if ((ack && m_credit == 1) || !req[m_cur]) begin
            m_ptr = (m_cur + 1) % N;
            m_on  = 1'b0; m_cur = 0; m_credit = 0;
            if (en && req != '0) m_pick();
        end else if (ack) begin
            m_credit = m_credit - 1;
        end
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] e;
        e = '0;
        if (m_on) e[m_cur] = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = 1'b0; en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; ack = 1'b0; req = 4'b1111; weight = '0;
        tick(); tick();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (gnt_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
        rst = 1'b0;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got=%b exp=1", busy); end
    endtask

    task automatic test_rotation();
        logic [N-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1}; req = 4'b1111; ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if (gnt !== seq[k]) begin n_fail++; $display("FAIL rotation_gnt[%0d] got=%b exp=%b", k, gnt, seq[k]); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rotation_busy[%0d] got=%b exp=1", k, busy); end
        end
    endtask

    task automatic test_weighted();
        logic [N-1:0] seq_a [5];
        logic [N-1:0] seq_b [5];
        seq_a[0] = 4'b0001; seq_a[1] = 4'b0001; seq_a[2] = 4'b0001; seq_a[3] = 4'b0010; seq_a[4] = 4'b0001;
        seq_b[0] = 4'b0001; seq_b[1] = 4'b0001; seq_b[2] = 4'b0001; seq_b[3] = 4'b0001; seq_b[4] = 4'b0010;
        do_reset();
        weight = {4'd0, 4'd0, 4'd0, 4'd3}; req = 4'b0011; ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if (gnt !== seq_a[k]) begin n_fail++; $display("FAIL weighted_gnt[%0d] got=%b exp=%b", k, gnt, seq_a[k]); end
        end
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            ack = (k == 1) ? 1'b0 : 1'b1;
            tick();
            n_tests++; if (gnt !== seq_b[k]) begin n_fail++; $display("FAIL weighted_stall_gnt[%0d] got=%b exp=%b", k, gnt, seq_b[k]); end
        end
    endtask

    task automatic test_sole_and_drop();
        do_reset();
        weight = {4'd0, 4'd2, 4'd0, 4'd0}; req = 4'b0100; ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL sole_gnt[%0d] got=%b exp=0100", k, gnt); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sole_busy[%0d] got=%b exp=1", k, busy); end
        end
        req = 4'b0000;
        tick();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_gnt got=%b exp=0000", gnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got=%b exp=0", busy); end
        req = 4'b1001;
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_next_gnt got=%b exp=1000", gnt); end
        n_tests++; if (gnt_idx !== 2'd3) begin n_fail++; $display("FAIL drop_next_idx got=%0d exp=3", gnt_idx); end
    endtask

    task automatic test_enable();
        logic [N-1:0] seq [6];
        seq[0] = 4'b0010; seq[1] = 4'b0010; seq[2] = 4'b0010; seq[3] = 4'b0010; seq[4] = 4'b0000; seq[5] = 4'b0000;
        do_reset();
        weight = {4'd0, 4'd0, 4'd4, 4'd0}; req = 4'b0110; ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) en = 1'b0;
            tick();
            n_tests++; if (gnt !== seq[k]) begin n_fail++; $display("FAIL enable_gnt[%0d] got=%b exp=%b", k, gnt, seq[k]); end
        end
        en = 1'b1;
        tick();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL enable_regrant got=%b exp=0100", gnt); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        weight = {4'd2, 4'd1, 4'd0, 4'd0}; req = 4'b1100; ack = 1'b1;
        tick();
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL midrst_pre_gnt got=%b exp=1000", gnt); end
        rst = 1'b1; req = 4'b1101;
        tick();
        n_tests++; if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_idx !== 2'd0) begin
            n_fail++; $display("FAIL midrst_clear got gnt=%b busy=%b idx=%0d exp gnt=0000 busy=0 idx=0", gnt, busy, gnt_idx);
        end
        rst = 1'b0;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_next_gnt got=%b exp=0001", gnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            en     = ($urandom_range(0, 7) != 0);
            ack    = ($urandom_range(0, 3) != 0);
            req    = N'($urandom) | (($urandom_range(0, 3) == 0) ? N'(0) : N'(1) << $urandom_range(0, N-1));
            if ($urandom_range(0, 9) == 0) req = '0;
            weight = (N*CW)'($urandom);
            tick();
            n_tests++;
            if (gnt !== m_gnt() || busy !== m_on || gnt_idx !== IW'(m_cur)) begin
                n_fail++;
                $display("FAIL random[%0d] got gnt=%b idx=%0d busy=%b exp gnt=%b idx=%0d busy=%b",
                         c, gnt, gnt_idx, busy, m_gnt(), m_cur, m_on);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ack = 1'b0; req = '0; weight = '0;
        m_on = 1'b0; m_ptr = 0; m_cur = 0; m_credit = 0;
        test_reset();
        test_rotation();
        test_weighted();
        test_sole_and_drop();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
